// File: rtl/lut_pkg.sv
// Shared widths, types and FSM encoding for the branch-target table and its reverse encoder.
package lut_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned TGT_W  = 10;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [TGT_W-1:0]  target_t;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    RESP
  } enc_state_t;

endpackage

// File: rtl/lut_store.sv
// Branch-target entry array with valid bits, write/clear port, forward read and a scan read port.
module lut_store
  import lut_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    wr_en_i,
  input  addr_t   wr_addr_i,
  input  target_t wr_data_i,
  input  logic    clr_all_i,
  input  addr_t   rd_addr_i,
  output target_t rd_target_o,
  input  addr_t   scan_idx_i,
  output target_t scan_target_o,
  output logic    scan_valid_o
);

  target_t          entry_q [DEPTH];
  target_t          entry_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;

  // A write on the same edge as clr_all keeps its own entry valid.
  always_comb begin
    entry_d = entry_q;
    valid_d = valid_q;
    if (clr_all_i) begin
      valid_d = '0;
    end
    if (wr_en_i) begin
      entry_d[wr_addr_i] = wr_data_i;
      valid_d[wr_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  assign rd_target_o   = valid_q[rd_addr_i] ? entry_q[rd_addr_i] : '0;
  assign scan_target_o = entry_q[scan_idx_i];
  assign scan_valid_o  = valid_q[scan_idx_i];

endmodule

// File: rtl/lut_target_encoder.sv
// Writable branch-target table with a one-entry-per-cycle reverse lookup (lowest pointer wins).
module lut_target_encoder
  import lut_pkg::*;
(
  input  logic    Clk,
  input  logic    Reset_n,
  input  logic    wr_en,
  input  addr_t   wr_addr,
  input  target_t wr_data,
  input  logic    clr_all,
  input  addr_t   rd_addr,
  output target_t rd_target,
  input  logic    req_valid,
  output logic    req_ready,
  input  target_t req_target,
  output logic    rsp_valid,
  input  logic    rsp_ready,
  output logic    rsp_hit,
  output addr_t   rsp_addr,
  output logic    busy
);

  enc_state_t state_q, state_d;
  addr_t      idx_q, idx_d;
  target_t    tgt_q, tgt_d;
  logic       hit_q, hit_d;
  addr_t      addr_q, addr_d;

  target_t    scan_target;
  logic       scan_valid;
  logic       scan_match;

  lut_store u_store (
    .clk_i         (Clk),
    .rst_ni        (Reset_n),
    .wr_en_i       (wr_en),
    .wr_addr_i     (wr_addr),
    .wr_data_i     (wr_data),
    .clr_all_i     (clr_all),
    .rd_addr_i     (rd_addr),
    .rd_target_o   (rd_target),
    .scan_idx_i    (idx_q),
    .scan_target_o (scan_target),
    .scan_valid_o  (scan_valid)
  );

  // Compares against the registered entry, so a write landing on this edge is not seen.
  assign scan_match = scan_valid && (scan_target == tgt_q);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      tgt_q   <= '0;
      hit_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tgt_q   <= tgt_d;
      hit_q   <= hit_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tgt_d   = tgt_q;
    hit_d   = hit_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          tgt_d   = req_target;
          idx_d   = '0;
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        if (scan_match) begin
          hit_d   = 1'b1;
          addr_d  = idx_q;
          state_d = RESP;
        end else if (idx_q == addr_t'(DEPTH - 1)) begin
          hit_d   = 1'b0;
          addr_d  = '0;
          state_d = RESP;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // req_ready is gated by reset so it reads 0 while Reset_n is held low.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE:    req_ready = Reset_n;
      SEARCH:  busy      = 1'b1;
      RESP: begin
        rsp_valid = 1'b1;
        busy      = 1'b1;
      end
      default: busy = 1'b1;
    endcase
  end

  assign rsp_hit  = hit_q;
  assign rsp_addr = addr_q;

endmodule

// File: doc/lut_target_encoder.md
Name: lut_target_encoder

Overview:
Writable branch-target table with a sequential reverse lookup. The forward direction maps a 5-bit pointer to a 10-bit PC target, unchanged from the current fetch path. The reverse direction takes a 10-bit target and searches for the lowest pointer holding that value. The table is loaded over a write port at boot, serves fetch-stage forward reads, and serves reverse queries from the program loader and self-check logic, which must encode branch targets into pointers.

Parameters:
ADDR_W, 5, pointer width
TGT_W, 10, PC target width
DEPTH, 32, entry count; must equal 2**ADDR_W

Ports:
Clk  in  1  clock, all state updates on rising edge
Reset_n  in  1  asynchronous active-low reset
wr_en  in  1  write strobe
wr_addr  in  ADDR_W  entry to write
wr_data  in  TGT_W  target value to write
clr_all  in  1  invalidate all entries
rd_addr  in  ADDR_W  forward lookup pointer
rd_target  out  TGT_W  forward lookup result, combinational
req_valid  in  1  reverse query valid
req_ready  out  1  query accepted when req_valid && req_ready
req_target  in  TGT_W  target to search for
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accepts result
rsp_hit  out  1  1 = match found
rsp_addr  out  ADDR_W  lowest matching pointer; 0 on miss
busy  out  1  state != IDLE

Behaviour:
- Storage: DEPTH x TGT_W registers plus a per-entry valid bit.
- Reset (async, Reset_n=0): all valid bits 0, all entries 0, FSM IDLE, search index 0. Outputs during reset: rsp_valid=0, rsp_hit=0, rsp_addr=0, busy=0, req_ready=0.
- After reset deasserts: req_ready=1 in IDLE.
- Reset asserted mid-search or mid-response aborts the operation. No response is produced.
- Write: on the edge where wr_en=1, entry[wr_addr]<=wr_data and valid[wr_addr]<=1.
- clr_all=1: all valid bits go to 0 on that edge.
- clr_all and wr_en on the same edge: the write wins for wr_addr; all other entries are cleared.
- Forward read: rd_target = valid[rd_addr] ? entry[rd_addr] : 0. It is purely combinational, and a write is visible the cycle after its edge.
- FSM states:
  - IDLE: req_ready=1. On req_valid: latch req_target, idx<=0, go to SEARCH.
  - SEARCH: req_ready=0. Each cycle compare entry[idx] against the latched target, qualified by valid[idx].
    - On match: rsp_hit<=1, rsp_addr<=idx, go to RESP.
    - Else if idx==DEPTH-1: rsp_hit<=0, rsp_addr<=0, go to RESP.
    - Else idx<=idx+1.
  - RESP: rsp_valid=1. rsp_hit and rsp_addr are held stable until rsp_ready=1, then go to IDLE. rsp_ready sampled in any other state is ignored.
- Latency: a hit at pointer k gives rsp_valid high k+1 cycles after the accept edge. A miss gives rsp_valid high DEPTH cycles after the accept edge. With rsp_ready held at 1, the minimum accept-to-accept interval is k+3 cycles.
- No back-to-back acceptance: req_ready is low from the accept edge until the RESP-to-IDLE transition.
- Lowest index wins. Duplicate values are legal.
- Write during SEARCH:
  - A write to an index not yet scanned is seen by the scan.
  - A write to the index being compared in the same cycle is not seen; the compare uses the old value.
  - An already-scanned index is not revisited.
- clr_all during SEARCH: same rule as writes, so unscanned entries become invalid.
- Writes or clears during RESP do not alter the held response.
- idx never exceeds DEPTH-1. There is no wrap-around within one search.

Decomposition:
- Package lut_pkg holds: ADDR_W and TGT_W localparams, addr_t and target_t typedefs, the enc_state_t enum {IDLE, SEARCH, RESP}.
- The forward LUT and this block both import lut_pkg.
- Sub-module lut_store holds the entry array, the valid bits, the write/clear logic, the combinational forward read, and a second indexed read port for the scan.
- The top level holds the FSM, the index counter, and the response registers.

Test Plan:
- Reset, then write ptr0=0x013, ptr1=0x020, ptr2=0x013, query 0x013 -> rsp_hit=1, rsp_addr=0, rsp_valid 1 cycle after accept.
- Write 0x03B at ptr4 only, query 0x03B -> rsp_hit=1, rsp_addr=4, rsp_valid 5 cycles after accept.
- Query 0x3FF against a table with no match -> rsp_hit=0, rsp_addr=0, rsp_valid 32 cycles after accept, busy high throughout.
- Hold rsp_ready=0 for 10 cycles in RESP while writing ptr0 and pulsing clr_all -> response unchanged, req_ready=0, no new query accepted.
- Query 0x04A; at scan idx=3 write 0x04A to ptr9 and ptr2 -> rsp_addr=9. Then clr_all+wr_en(ptr5,0x040) on one edge, rd_addr=5 -> 0x040, rd_addr=9 -> 0.
- Assert Reset_n=0 at scan idx=6 -> rsp_valid stays 0. After release: busy=0, req_ready=1, all rd_target=0.
